// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and widths for the 32-bit-word to 16-bit-SRAM access controller.
package mem_access_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int WORD_W  = 32;
  localparam int IDX_W   = 17;
  localparam int WAIT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [SRAM_AW-1:0] half_addr(input logic [IDX_W-1:0] word_idx,
                                                   input logic hi);
    return {word_idx, hi};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and SRAM-side bus of the memory access controller.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  // Handshake: the pipeline holds MEM_R_EN/MEM_W_EN, ALURes and STVal stable while freeze is 1;
  // the cycle a request is seen with freeze 0 is the completion cycle, and readData is valid then.
  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic [WORD_W-1:0]  ALURes;
  logic [WORD_W-1:0]  STVal;
  logic [WORD_W-1:0]  readData;
  logic               freeze;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [SRAM_DW-1:0] SRAM_DQ_OUT;
  logic               SRAM_DQ_OE;
  logic [SRAM_DW-1:0] SRAM_DQ_IN;
  logic               SRAM_WE_N;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALURes, STVal, SRAM_DQ_IN,
    output readData, freeze, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALURes, STVal, SRAM_DQ_IN,
    input  readData, freeze, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then high half),
// freezing the pipeline until the access completes. SRAM_WAIT must be in 0..7.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  output state_t            o_dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_WAIT);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_is_write;
  logic [IDX_W-1:0]   r_word_idx;
  logic [SRAM_DW-1:0] r_st_hi;
  logic [WORD_W-1:0]  r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;

  logic               w_req;
  logic               w_phase_end;
  logic               w_unused_alu;

  assign w_req        = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_phase_end  = (r_wait_cnt == WAIT_LAST);
  assign w_unused_alu = ^{bus.ALURes[31:19], bus.ALURes[1:0]};

  // SRAM strobes are registered and loaded on the edge that enters each phase,
  // so they are already valid during the first cycle of LOW and HIGH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_is_write  <= 1'b0;
      r_word_idx  <= '0;
      r_st_hi     <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_req) begin
            r_state     <= LOW;
            r_is_write  <= bus.MEM_W_EN;
            r_word_idx  <= bus.ALURes[18:2];
            r_st_hi     <= bus.STVal[31:16];
            r_sram_addr <= half_addr(bus.ALURes[18:2], 1'b0);
            r_we_n      <= ~bus.MEM_W_EN;
            r_dq_oe     <= bus.MEM_W_EN;
            r_dq_out    <= bus.MEM_W_EN ? bus.STVal[15:0] : '0;
          end
        end
        LOW: begin
          if (w_phase_end) begin
            r_state     <= HIGH;
            r_wait_cnt  <= '0;
            r_sram_addr <= half_addr(r_word_idx, 1'b1);
            r_dq_out    <= r_is_write ? r_st_hi : '0;
            if (!r_is_write) r_read_data[15:0] <= bus.SRAM_DQ_IN;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_state     <= DONE;
            r_wait_cnt  <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            if (!r_is_write) r_read_data[31:16] <= bus.SRAM_DQ_IN;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // The pipeline is released exactly in DONE so the next request lands in IDLE.
  assign bus.freeze      = w_req && (r_state != DONE);
  assign bus.readData    = r_read_data;
  assign bus.SRAM_ADDR   = r_sram_addr;
  assign bus.SRAM_DQ_OUT = r_dq_out;
  assign bus.SRAM_DQ_OE  = r_dq_oe;
  assign bus.SRAM_WE_N   = r_we_n;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word-level memory model plus scoreboard against a half-word SRAM model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int W   = 1;
  localparam int LAT = 2 * (W + 1) + 2;

  typedef struct packed {
    logic        wr;
    logic [7:0]  idx;
    logic [31:0] word;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus0 ();
  state_t dbg_state;
  state_t dbg_state0;

  mem_access_ctrl #(.SRAM_WAIT(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  mem_access_ctrl #(.SRAM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .o_dbg_state(dbg_state0)
  );

  // Asynchronous-read SRAM model for the main instance; fixed pattern for the zero-wait one.
  logic [15:0] sram [0:1023];
  assign bus.SRAM_DQ_IN  = sram[bus.SRAM_ADDR[9:0]];
  assign bus0.SRAM_DQ_IN = bus0.SRAM_ADDR[15:0] ^ 16'h5A5A;
  always @(posedge clk) if (!bus.SRAM_WE_N) sram[bus.SRAM_ADDR[9:0]] = bus.SRAM_DQ_OUT;

  // Reference: memory seen as 32-bit words, plus the last completed read.
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rd;
  exp_t        exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done = 0;
  int busy_cyc = 0;
  int we_low_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a request seen with freeze low is a completion; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_cyc   = 0;
      we_low_cyc = 0;
    end else if (bus.MEM_R_EN | bus.MEM_W_EN) begin
      if (!bus.SRAM_WE_N) we_low_cyc++;
      if (bus.freeze) begin
        busy_cyc++;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got completion at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("readData", 64'(bus.readData), 64'(e.rd));
        check("freeze_cycles", 64'(busy_cyc), 64'(LAT - 1));
        check("we_n_low_cycles", 64'(we_low_cyc), e.wr ? 64'(2 * (W + 1)) : 64'd0);
        check("done_bus_idle", {bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_DQ_OUT},
              {18'd0, 1'b1, 1'b0, 16'd0});
        if (e.wr) check("sram_word", 64'({sram[{e.idx, 1'b1}], sram[{e.idx, 1'b0}]}), 64'(e.word));
        last_done  = cyc;
        busy_cyc   = 0;
        we_low_cyc = 0;
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [31:0] alu, input logic [31:0] d);
    exp_t e;
    logic [7:0] idx;
    int n;
    idx = alu[9:2];
    @(posedge clk); #1;
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.ALURes   = alu;
    bus.STVal    = d;
    if (w) ref_mem[idx] = d;
    else if (r) ref_rd = ref_mem[idx];
    e.wr = w; e.idx = idx; e.word = ref_mem[idx]; e.rd = ref_rd;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.freeze && n < 40);
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got freeze still high after %0d cycles, expected %0d", n, LAT);
    end
    #1;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int t1;
    int n;
    logic [31:0] alu;
    int op;
    bus.MEM_R_EN = 0; bus.MEM_W_EN = 0; bus.ALURes = 0; bus.STVal = 0;
    bus0.MEM_R_EN = 0; bus0.MEM_W_EN = 0; bus0.ALURes = 0; bus0.STVal = 0;
    for (int k = 0; k < 1024; k++) sram[k] = 16'($urandom);
    for (int j = 0; j < 256; j++) ref_mem[j] = {sram[2 * j + 1], sram[2 * j]};
    ref_rd = 32'd0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readData", 64'(bus.readData), 64'd0);
    check("rst_bus", {bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_DQ_OUT},
          {18'd0, 1'b1, 1'b0, 16'd0});
    check("rst_freeze", 64'(bus.freeze), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed read: halves 0x1234 / 0xABCD at half-word addresses 8 / 9.
    sram[8] = 16'h1234;
    sram[9] = 16'hABCD;
    ref_mem[4] = 32'hABCD_1234;
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle(2);
    issue(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    check("write_lo_16", 64'(sram[16]), 64'hBEEF);
    check("write_hi_17", 64'(sram[17]), 64'hDEAD);
    issue(1'b1, 1'b1, 32'h0000_0024, 32'h55AA_00FF);
    idle(1);

    // Back-to-back reads: DONE pulses span LAT+1 cycles inclusive.
    issue(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    t1 = last_done;
    issue(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    check("b2b_done_span", 64'(last_done - t1 + 1), 64'(LAT + 1));

    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 2);
      alu = {13'($urandom), 9'd0, 8'($urandom), 2'($urandom)};
      issue(op != 1, op != 0, alu, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    // Reset during the second LOW cycle of a write aborts it after the low half.
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b1; bus.MEM_R_EN = 1'b0;
    bus.ALURes = 32'h0000_0030; bus.STVal = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    check("abort_bus", {bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_DQ_OUT},
          {18'd0, 1'b1, 1'b0, 16'd0});
    check("abort_freeze_req", 64'(bus.freeze), 64'd1);
    check("abort_readData", 64'(bus.readData), 64'd0);
    ref_mem[12] = {ref_mem[12][31:16], 16'hF00D};
    ref_rd = 32'd0;
    check("abort_sram_word", 64'({sram[25], sram[24]}), 64'(ref_mem[12]));
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b0;
    @(negedge clk);
    check("abort_freeze_noreq", 64'(bus.freeze), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    idle(1);

    // Zero-wait instance: freeze for 3 cycles, data from the address pattern.
    @(posedge clk); #1;
    bus0.MEM_R_EN = 1'b1;
    bus0.ALURes   = 32'h0000_0040;
    n = 0;
    begin : w0_loop
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!bus0.freeze) disable w0_loop;
        n++;
      end
    end
    check("w0_freeze_cycles", 64'(n), 64'd3);
    check("w0_readData", 64'(bus0.readData), 64'({16'h0021 ^ 16'h5A5A, 16'h0020 ^ 16'h5A5A}));
    @(posedge clk); #1;
    bus0.MEM_R_EN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("w0_readData_hold", 64'(bus0.readData), 64'({16'h0021 ^ 16'h5A5A, 16'h0020 ^ 16'h5A5A}));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
